// File: rtl/pmm_avl_pkg.sv
// Shared definitions for the partial-matrix-multiply Avalon-MM link.
// Holds the master's state encoding, the slave register map (also used by
// the slave adapter so both ends agree on addresses) and the default
// data/result widths.
package pmm_avl_pkg;

  localparam int PMM_DATA_W = 32;  // Avalon data / operand width
  localparam int PMM_RES_W  = 18;  // significant bits of the product

  // Slave register map
  localparam logic [1:0] PMM_ADDR_A = 2'b00;  // operand A (write)
  localparam logic [1:0] PMM_ADDR_B = 2'b01;  // operand B (write)
  localparam logic [1:0] PMM_ADDR_R = 2'b10;  // result    (read)

  typedef enum logic [2:0] {
    IDLE,     // waiting for an operand pair
    WR_A,     // write of operand A outstanding
    WR_B,     // write of operand B outstanding
    RD_REQ,   // read request outstanding
    RD_WAIT,  // read accepted, waiting for readdatavalid
    PUSH      // result offered on the result stream
  } state_e;

endpackage

// File: rtl/avl_mm_pmm_master.sv
// Avalon-MM master for the partial-matrix-multiply slave.
// Takes operand pairs on a valid/ready stream, writes A and B to the slave,
// reads the product back and offers it on a valid/ready result stream.
//
// Ports:
//   _CLK, _RST            clock, asynchronous active-high reset
//   _OP_A/_OP_B/_OP_VALID operand pair stream in; OP_READY_ accepts it
//   RES_DATA_/RES_VALID_  result stream out; _RES_READY accepts it
//   _CLR_ERR              clears the sticky TIMEOUT_ERR_ flag
//   AVM_*                 Avalon-MM master outputs
//   _AVM_*                Avalon-MM slave responses
//   BUSY_                 a transaction is in progress
//   TIMEOUT_ERR_          sticky: a read never returned data in time
//   XFER_CNT_             completed results, wraps
module avl_mm_pmm_master
  import pmm_avl_pkg::*;
#(
  parameter int         DATA_W  = PMM_DATA_W,
  parameter int         RES_W   = PMM_RES_W,
  parameter logic [1:0] ADDR_A  = PMM_ADDR_A,
  parameter logic [1:0] ADDR_B  = PMM_ADDR_B,
  parameter logic [1:0] ADDR_R  = PMM_ADDR_R,
  parameter int         TIMEOUT = 15,
  parameter int         CNT_W   = 16
) (
  input  logic              _CLK,
  input  logic              _RST,
  input  logic [DATA_W-1:0] _OP_A,
  input  logic [DATA_W-1:0] _OP_B,
  input  logic              _OP_VALID,
  output logic              OP_READY_,
  output logic [RES_W-1:0]  RES_DATA_,
  output logic              RES_VALID_,
  input  logic              _RES_READY,
  input  logic              _CLR_ERR,
  output logic              AVM_CS_,
  output logic [1:0]        AVM_ADDR_,
  output logic              AVM_WRITE_,
  output logic              AVM_READ_,
  output logic [DATA_W-1:0] AVM_WRITEDATA_,
  input  logic [DATA_W-1:0] _AVM_READDATA,
  input  logic              _AVM_WAITREQUEST,
  input  logic              _AVM_READDATAVALID,
  output logic              BUSY_,
  output logic              TIMEOUT_ERR_,
  output logic [CNT_W-1:0]  XFER_CNT_
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_e              state_q;
  logic [DATA_W-1:0]   op_b_q;      // A goes straight into wdata_q; only B must wait
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          addr_q;
  logic                write_q;
  logic                read_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [RES_W-1:0]    res_data_q;
  logic                res_valid_q;
  logic                err_q;
  logic [CNT_W-1:0]    xfer_cnt_q;

  // NOTE: every state register uses <= so all of them see the pre-edge values
  // and the async reset branch clears the complete set, abandoning any
  // transaction and dropping every strobe immediately.
  always_ff @(posedge _CLK or posedge _RST) begin
    if (_RST) begin
      state_q     <= IDLE;
      op_b_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      to_cnt_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      // NOTE: the clear is written before the case so a timeout set issued
      // later in this block on the same edge overrides it.
      if (_CLR_ERR) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (_OP_VALID) begin
            op_b_q  <= _OP_B;
            wdata_q <= _OP_A;
            addr_q  <= ADDR_A;
            write_q <= 1'b1;
            state_q <= WR_A;
          end
        end
        WR_A: begin
          if (!_AVM_WAITREQUEST) begin
            wdata_q <= op_b_q;
            addr_q  <= ADDR_B;
            state_q <= WR_B;
          end
        end
        WR_B: begin
          if (!_AVM_WAITREQUEST) begin
            write_q <= 1'b0;
            read_q  <= 1'b1;
            addr_q  <= ADDR_R;
            state_q <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!_AVM_WAITREQUEST) begin
            read_q   <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (_AVM_READDATAVALID) begin
            res_data_q  <= _AVM_READDATA[RES_W-1:0];
            res_valid_q <= 1'b1;
            state_q     <= PUSH;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th empty cycle: give up on the read.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        PUSH: begin
          if (_RES_READY) begin
            res_valid_q <= 1'b0;
            xfer_cnt_q  <= xfer_cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bits above the result width carry nothing the multiplier produces.
  logic unused_readdata;
  assign unused_readdata = &{1'b0, _AVM_READDATA[DATA_W-1:RES_W]};

  assign OP_READY_      = (state_q == IDLE);
  assign BUSY_          = (state_q != IDLE);
  assign AVM_CS_        = write_q | read_q;
  assign AVM_ADDR_      = addr_q;
  assign AVM_WRITE_     = write_q;
  assign AVM_READ_      = read_q;
  assign AVM_WRITEDATA_ = wdata_q;
  assign RES_DATA_      = res_data_q;
  assign RES_VALID_     = res_valid_q;
  assign TIMEOUT_ERR_   = err_q;
  assign XFER_CNT_      = xfer_cnt_q;

endmodule

// File: doc/avl_mm_pmm_master.md
Name: avl_mm_pmm_master

Overview:
Avalon-MM master that drives the partial-matrix-multiply slave adapter. It accepts operand pairs on a valid/ready stream and issues write A (addr 0), write B (addr 1) and read result (addr 2). It returns each product on a valid/ready result stream. It sits between the matrix sequencing logic and the multiplier slave, so the multiplier can run without a soft CPU.

Parameters:
DATA_W, 32, Avalon data width and operand width
RES_W, 18, result width taken from readdata[RES_W-1:0]
ADDR_A, 2'b00, slave address of operand A
ADDR_B, 2'b01, slave address of operand B
ADDR_R, 2'b10, slave address of result
TIMEOUT, 15, max cycles waiting for readdatavalid
CNT_W, 16, width of completed-transfer counter

Ports:
_CLK  in  1  clock
_RST  in  1  reset, asynchronous, active-high
_OP_A  in  DATA_W  operand A
_OP_B  in  DATA_W  operand B
_OP_VALID  in  1  operand pair valid
OP_READY_  out  1  operand pair accepted when high with _OP_VALID
RES_DATA_  out  RES_W  result
RES_VALID_  out  1  result valid
_RES_READY  in  1  result consumer ready
_CLR_ERR  in  1  clears TIMEOUT_ERR_
AVM_CS_  out  1  chip select
AVM_ADDR_  out  2  address
AVM_WRITE_  out  1  write strobe
AVM_READ_  out  1  read strobe
AVM_WRITEDATA_  out  DATA_W  write data
_AVM_READDATA  in  DATA_W  read data
_AVM_WAITREQUEST  in  1  slave stall
_AVM_READDATAVALID  in  1  read data valid
BUSY_  out  1  state != IDLE
TIMEOUT_ERR_  out  1  sticky read-timeout flag
XFER_CNT_  out  CNT_W  completed results, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, _RST high): state IDLE. All outputs 0: RES_DATA_, RES_VALID_, AVM_*, BUSY_, TIMEOUT_ERR_, XFER_CNT_. Operand registers cleared. Reset mid-transaction abandons the transaction; no Avalon strobe is asserted after reset.
- OP_READY_ = (state == IDLE), combinational from state only. Handshake on the edge where _OP_VALID & OP_READY_: latch A and B, go to WR_A.
- WR_A: CS=1, WRITE=1, ADDR=ADDR_A, WRITEDATA=A. Hold all signals stable while _AVM_WAITREQUEST=1. On an edge with waitrequest=0, go to WR_B.
- WR_B: same as WR_A with ADDR_B and B; on accept go to RD_REQ.
- RD_REQ: CS=1, READ=1, ADDR=ADDR_R, WRITEDATA unchanged. Hold while waitrequest=1. On accept go to RD_WAIT and clear the timeout counter.
- RD_WAIT: all strobes 0.
  - _AVM_READDATAVALID=1: capture readdata[RES_W-1:0] into RES_DATA_, go to PUSH.
  - Otherwise the counter increments. When the counter reaches TIMEOUT without valid: set TIMEOUT_ERR_, drop the result, go to IDLE.
- PUSH: RES_VALID_=1, RES_DATA_ stable. On an edge with _RES_READY=1: go to IDLE and increment XFER_CNT_; all-ones wraps to 0.
- Readdatavalid outside RD_WAIT is ignored.
- AVM_WRITE_ and AVM_READ_ are never high together. AVM_CS_ = WRITE|READ.
- TIMEOUT_ERR_: set by timeout, cleared by _CLR_ERR. If both occur on the same edge, set wins.
- Latency with no waitrequest and readdatavalid one cycle after read accept:
  - op accept edge E0; write A at E1; write B at E2; read at E3; capture at E4.
  - RES_VALID_ high after E4.
  - With _RES_READY=1, the next op is accepted at E6, so the minimum interval is 6 cycles per op.
- All outputs are registered except OP_READY_, BUSY_ and AVM_CS_, which are decoded from registered state.

Decomposition:
- Shared package pmm_avl_pkg: state enum (IDLE, WR_A, WR_B, RD_REQ, RD_WAIT, PUSH), ADDR_A/ADDR_B/ADDR_R constants, DATA_W/RES_W defaults; the slave adapter uses the same address constants.
- Single module; no sub-module. The timeout counter and transfer counter stay inline.

Test Plan:
- Basic op: A=32'h04030201, B=32'h01010101, zero waitrequest, slave model returns 18'd10 one cycle after read → Avalon sequence writes addr 0 (04030201) then addr 1 (01010101), then reads addr 2; RES_DATA_=10 with RES_VALID_ high 4 cycles after accept; XFER_CNT_=1.
- Waitrequest stall: hold waitrequest=1 for 3 cycles during each of WR_A, WR_B and RD_REQ → address and data stay stable through each stall, each access completes exactly once, result is correct, latency is 4+9 cycles.
- Backpressure: _RES_READY=0 for 5 cycles → RES_VALID_ and RES_DATA_ stay stable, OP_READY_=0 throughout; after ready, the next op is accepted 2 cycles later.
- Timeout: readdatavalid never asserted → after 15 cycles in RD_WAIT, TIMEOUT_ERR_=1, no RES_VALID_, state returns to IDLE; _CLR_ERR pulse → flag returns to 0.
- Reset mid-read: assert _RST while in RD_REQ with waitrequest=1 → all outputs go to 0 immediately; the next op after release runs normally.
- Counter wrap with CNT_W=2: 5 back-to-back ops → XFER_CNT_ reads 1,2,3,0,1.
